// File: rtl/dct_ctrl_pkg.sv
// Shared definitions for the 8-point 1D-DCT sequencer.
//   state_t      : controller states (StClear only when AUTO_CLR_EN is defined)
//   SEL_COMPUTE  : select code that makes the datapath advance one pipeline stage
//   SAMPLES      : samples per block
//   COMPUTE_MIN  : smallest compute-strobe count that still covers stages A..F
//   sel_code()   : sample index -> datapath select code
package dct_ctrl_pkg;

    localparam logic [7:0]  SEL_COMPUTE = 8'h80;
    localparam int unsigned SAMPLES     = 8;
    localparam int unsigned COMPUTE_MIN = 6;
    localparam int unsigned COMPUTE_MAX = 15;

    typedef enum logic [2:0] {
        StLoad,
        StCompute,
        StOutput,
        StHold
`ifdef AUTO_CLR_EN
        , StClear
`endif
    } state_t;

    // Index 0 writes I0 (code 0x00); indices 1..7 use a one-hot code.
    function automatic logic [7:0] sel_code(input logic [2:0] idx);
        if (idx == 3'd0) begin
            return 8'h00;
        end
        return 8'h01 << (idx - 3'd1);
    endfunction

endpackage

// File: rtl/dct_sel_decode.sv
// Combinational decoder from sample index to datapath select code.
//   idx  : 3-bit sample index
//   code : 8-bit select code placed in dct_sw[15:8]
module dct_sel_decode
    import dct_ctrl_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] code
);

    assign code = sel_code(idx);

endmodule

// File: rtl/dct_seq_ctrl.sv
// Sequencer for the 8-point 1D-DCT datapath: loads eight samples from a
// valid/ready stream, issues COMPUTE_CYCLES compute strobes, one out strobe,
// then holds a result-valid handshake for the downstream consumer.
// Optional feature macro: AUTO_CLR_EN adds one datapath clear cycle after
// every result handshake; without it dct_clr is tied low.
// Ports:
//   clk, clr_n          : clock, asynchronous active-low reset
//   in_data/valid/ready : sample stream (ready only in LOAD)
//   dct_sw              : {select code, sample data} to the datapath
//   dct_enable/out/clr  : datapath strobes (mutually exclusive)
//   res_valid/ready     : result handshake with the consumer
//   busy                : low only when idle in LOAD at sample index 0
//   blk_cnt             : completed-block counter, wraps silently
module dct_seq_ctrl
    import dct_ctrl_pkg::*;
#(
    parameter int unsigned COMPUTE_CYCLES = 6,
    parameter int unsigned BLK_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [15:0]          dct_sw,
    output logic                 dct_enable,
    output logic                 dct_out,
    output logic                 dct_clr,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy,
    output logic [BLK_CNT_W-1:0] blk_cnt
);

    if ((COMPUTE_CYCLES < COMPUTE_MIN) || (COMPUTE_CYCLES > COMPUTE_MAX)) begin : g_bad_cycles
        $error("dct_seq_ctrl: COMPUTE_CYCLES must be within 6..15");
    end

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cmp_cnt;
    logic [7:0] sel;
    logic       accept;

    assign accept = in_valid & in_ready;

    dct_sel_decode u_sel_decode (
        .idx  (idx),
        .code (sel)
    );

    // All outputs are registered; each state sets the outputs that must be
    // visible during the following cycle. The datapath treats sw=0 as a write
    // to I0, so dct_enable defaults low on every edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= StLoad;
            idx        <= 3'd0;
            cmp_cnt    <= 4'd0;
            dct_sw     <= 16'h0000;
            dct_enable <= 1'b0;
            dct_out    <= 1'b0;
            res_valid  <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            blk_cnt    <= '0;
`ifdef AUTO_CLR_EN
            dct_clr    <= 1'b0;
`endif
        end else begin
            dct_enable <= 1'b0;
            dct_out    <= 1'b0;
`ifdef AUTO_CLR_EN
            dct_clr    <= 1'b0;
`endif
            unique case (state)
                StLoad: begin
                    in_ready <= 1'b1;
                    busy     <= (idx != 3'd0);
                    if (accept) begin
                        dct_sw     <= {sel, in_data};
                        dct_enable <= 1'b1;
                        busy       <= 1'b1;
                        if (idx == 3'(SAMPLES - 1)) begin
                            idx      <= 3'd0;
                            cmp_cnt  <= 4'(COMPUTE_CYCLES - 1);
                            in_ready <= 1'b0;
                            state    <= StCompute;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                StCompute: begin
                    dct_sw     <= {SEL_COMPUTE, 8'h00};
                    dct_enable <= 1'b1;
                    if (cmp_cnt == 4'd0) begin
                        state <= StOutput;
                    end else begin
                        cmp_cnt <= cmp_cnt - 4'd1;
                    end
                end
                StOutput: begin
                    dct_out <= 1'b1;
                    state   <= StHold;
                end
                StHold: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        blk_cnt   <= blk_cnt + BLK_CNT_W'(1);
`ifdef AUTO_CLR_EN
                        dct_clr   <= 1'b1;
                        state     <= StClear;
`else
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StLoad;
`endif
                    end else begin
                        res_valid <= 1'b1;
                    end
                end
`ifdef AUTO_CLR_EN
                StClear: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= StLoad;
                end
`endif
                default: begin
                    state <= StLoad;
                end
            endcase
        end
    end

`ifndef AUTO_CLR_EN
    assign dct_clr = 1'b0;
`endif

    a_strobe_excl: assert property (@(posedge clk) disable iff (!clr_n)
        $onehot0({dct_enable, dct_out, dct_clr}))
        else $error("dct_seq_ctrl: datapath strobes overlap");

endmodule

// File: tb/tb_dct_seq_ctrl.sv
// Self-checking bench for dct_seq_ctrl with a small behavioural datapath model.
module tb_dct_seq_ctrl;

    localparam int unsigned CC    = 6;
    localparam int unsigned BW    = 4;
    localparam longint      SCALE = 256 * 1448;

    logic          clk = 1'b0;
    logic          clr_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   dct_sw;
    logic          dct_enable;
    logic          dct_out;
    logic          dct_clr;
    logic          res_valid;
    logic          res_ready;
    logic          busy;
    logic [BW-1:0] blk_cnt;

    dct_seq_ctrl #(
        .COMPUTE_CYCLES (CC),
        .BLK_CNT_W      (BW)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dct_sw     (dct_sw),
        .dct_enable (dct_enable),
        .dct_out    (dct_out),
        .dct_clr    (dct_clr),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy),
        .blk_cnt    (blk_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_bad    = 0;
    int          cyc      = 0;
    int          acc7_cyc = 0;
    int          exp_blk  = 0;
    logic [15:0] exp_sw[$];
    longint      exp_g[$];
    int          dp_i[8];
    longint      dp_g0 = 0;
    logic [7:0]  blk_s[8];

    typedef struct {
        logic [7:0] base;
        int         step;
        bit         gaps;
        int         hold;
        longint     exp_g0;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_sel(input int k);
        case (k)
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h02;
            3: return 8'h04;
            4: return 8'h08;
            5: return 8'h10;
            6: return 8'h20;
            7: return 8'h40;
            default: return 8'hff;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model plus select-word scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (clr_n) begin
            check("strobe_excl", longint'($countones({dct_enable, dct_out, dct_clr}) <= 1), 1);
            if (dct_enable) begin
                if (exp_sw.size() == 0) begin
                    check("spurious_enable", dct_enable, 0);
                end else begin
                    check("dct_sw", dct_sw, exp_sw.pop_front());
                end
                if (dct_sw[15:8] == 8'h00) begin
                    dp_i[0] = int'($signed(dct_sw[7:0]));
                end else if (dct_sw[15:8] != 8'h80) begin
                    for (int b = 0; b < 7; b++) begin
                        if (dct_sw[15:8] == (8'h01 << b)) dp_i[b+1] = int'($signed(dct_sw[7:0]));
                    end
                end
            end
            if (dct_out) begin
                longint s;
                s = 0;
                for (int i = 0; i < 8; i++) s += dp_i[i];
                dp_g0 = s * SCALE;
            end
            if (dct_clr) begin
                for (int i = 0; i < 8; i++) dp_i[i] = 0;
                dp_g0 = 0;
            end
        end
    end

    task automatic put_sample(input logic [7:0] d, input int k);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", longint'(t < 40), 1);
        exp_sw.push_back({exp_sel(k), d});
        if (k == 7) begin
            acc7_cyc = cyc + 1;
            for (int c = 0; c < CC; c++) exp_sw.push_back(16'h8000);
        end
    endtask

    task automatic send_block(input bit gaps);
        for (int k = 0; k < 8; k++) begin
            put_sample(blk_s[k], k);
            if (gaps) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'ha5;
            end
        end
        if (!gaps) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'h5a;
        end
    endtask

    task automatic wait_result(input int hold);
        int t;
        if (hold == 0) res_ready = 1'b1;
        t = 0;
        while (!res_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("res_valid_rise", res_valid, 1);
        check("latency", cyc - acc7_cyc, CC + 2);
        check("busy_hold", busy, 1);
        check("in_ready_hold", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_strobes", {dct_enable, dct_out, dct_clr}, 0);
            check("hold_in_ready", in_ready, 0);
            check("hold_blk_cnt", blk_cnt, exp_blk % 16);
        end
        res_ready = 1'b1;
        check("g0", dp_g0, exp_g.pop_front());
        check("sw_queue_drained", exp_sw.size(), 0);
        @(negedge clk);
        res_ready = 1'b0;
        exp_blk++;
        check("res_valid_drop", res_valid, 0);
        check("blk_cnt", blk_cnt, exp_blk % 16);
`ifdef AUTO_CLR_EN
        check("clr_cycle", dct_clr, 1);
        check("in_ready_clr", in_ready, 0);
        @(negedge clk);
        check("clr_done", dct_clr, 0);
        check("in_ready_back", in_ready, 1);
`else
        check("no_clr", dct_clr, 0);
        check("in_ready_back", in_ready, 1);
`endif
        check("busy_idle", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sw"}, dct_sw, 0);
        check({tag, "_en"}, dct_enable, 0);
        check({tag, "_out"}, dct_out, 0);
        check({tag, "_clr"}, dct_clr, 0);
        check({tag, "_rv"}, res_valid, 0);
        check({tag, "_rdy"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_blk"}, blk_cnt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{base: 8'h10, step: 0, gaps: 1'b0, hold: 0,  exp_g0: 64'sd47448064};
        vecs[1] = '{base: 8'h10, step: 0, gaps: 1'b1, hold: 20, exp_g0: 64'sd47448064};
        vecs[2] = '{base: 8'hfd, step: 5, gaps: 1'b0, hold: 3,  exp_g0: 64'sd42999808};
        vecs[3] = '{base: 8'h80, step: 0, gaps: 1'b1, hold: 0,  exp_g0: -64'sd379584512};
        vecs[4] = '{base: 8'h7f, step: 0, gaps: 1'b0, hold: 1,  exp_g0: 64'sd376619008};

        for (int i = 0; i < 8; i++) dp_i[i] = 0;
        clr_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        res_ready = 1'b0;
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        #2 clr_n = 1'b1;
        @(negedge clk);
        check("rdy_after_reset", in_ready, 1);
        check("busy_after_reset", busy, 0);

        // First block back-to-back, then a reset in the middle of a load.
        for (int k = 0; k < 8; k++) blk_s[k] = vecs[0].base;
        exp_g.push_back(vecs[0].exp_g0);
        send_block(1'b0);
        wait_result(0);

        for (int k = 0; k < 5; k++) put_sample(8'(k * 3 + 1), k);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_midload", busy, 1);
        #2 clr_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_sw.delete();
        exp_blk = 0;
        @(negedge clk);
        #2 clr_n = 1'b1;
        @(negedge clk);
        check("rdy_after_midreset", in_ready, 1);

        // 17 blocks: the table, then random ones; blk_cnt wraps after 16.
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 8; k++) blk_s[k] = vecs[v].base + 8'(vecs[v].step * k);
            exp_g.push_back(vecs[v].exp_g0);
            send_block(vecs[v].gaps);
            wait_result(vecs[v].hold);
        end
        for (int b = 0; b < 12; b++) begin
            longint s;
            s = 0;
            for (int k = 0; k < 8; k++) begin
                blk_s[k] = 8'($urandom_range(0, 255));
                s += longint'($signed(blk_s[k]));
            end
            exp_g.push_back(s * SCALE);
            send_block(b[0]);
            wait_result(b % 3);
        end
        check("blk_cnt_final", blk_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
